out_align_checker: RTL and testbench

OUT_ALIGN_CHECKER -- requirements
Module: out_align_checker

---
 rtl/out_align_checker.sv | 156 +++++++++++++++
 tb/tb_out_align_checker.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/out_align_checker.sv
// out_align_checker: checks that a delayed copy's pop/data stream replays the undelayed copy's stream in order.
// Optional OUT_ALIGN_DATA_CHK_EN: buffer and compare data_out alongside the pop vectors.
`default_nettype none

module out_align_checker #(
    parameter int NUM_REQS = 2,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_REQS-1:0]        pop0,
    input  logic [NUM_REQS-1:0]        pop1,
    input  logic [WIDTH-1:0]           data_out0,
    input  logic [WIDTH-1:0]           data_out1,
    output logic                       prop_signal,
    output logic                       mismatch,
    output logic                       overflow,
    output logic                       underflow,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       in_sync
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

`ifdef OUT_ALIGN_DATA_CHK_EN
    localparam int ENTRY_W = NUM_REQS + WIDTH;
    logic [ENTRY_W-1:0] entry0, entry1;
    assign entry0 = {pop0, data_out0};
    assign entry1 = {pop1, data_out1};
`else
    localparam int ENTRY_W = NUM_REQS;
    logic [ENTRY_W-1:0] entry0, entry1;
    logic               unused_data;
    assign entry0      = pop0;
    assign entry1      = pop1;
    assign unused_data = ^{data_out0, data_out1};
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAIL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               mismatch_q, mismatch_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               push;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] head;
    logic               ev0, ev1, empty, full;

    assign ev0   = |pop0;
    assign ev1   = |pop1;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);
    assign head  = mem_q[rd_ptr_q];

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mismatch_d  = mismatch_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = TRACK;
            end
            TRACK: begin
                if (ev0 && ev1) begin
                    if (empty) begin
                        if (entry0 != entry1) mismatch_d = 1'b1;
                    end else begin
                        if (head != entry1) mismatch_d = 1'b1;
                        push     = 1'b1;
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                        rd_ptr_d = ptr_inc(rd_ptr_q);
                    end
                end else if (ev0) begin
                    if (full) begin
                        overflow_d = 1'b1;
                    end else begin
                        push     = 1'b1;
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                        count_d  = count_q + 1'b1;
                    end
                end else if (ev1) begin
                    if (empty) begin
                        underflow_d = 1'b1;
                    end else begin
                        if (head != entry1) mismatch_d = 1'b1;
                        rd_ptr_d = ptr_inc(rd_ptr_q);
                        count_d  = count_q - 1'b1;
                    end
                end
                if (mismatch_d || overflow_d || underflow_d) state_d = FAIL;
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mismatch_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mismatch_q  <= mismatch_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (rst && push) mem_q[wr_ptr_q] <= entry0;
    end

    assign prop_signal = (state_q != FAIL);
    assign in_sync     = (state_q == TRACK) && (count_q == '0);
    assign mismatch    = mismatch_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign count       = count_q;

endmodule

`default_nettype wire

// File: tb/tb_out_align_checker.sv
// Directed self-checking bench for out_align_checker (NUM_REQS=2, WIDTH=8, DEPTH=4).
`default_nettype none

module tb_out_align_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] pop0 = '0, pop1 = '0;
    logic [7:0] data_out0 = '0, data_out1 = '0;
    logic       prop_signal, mismatch, overflow, underflow, in_sync;
    logic [2:0] count;

    int n_assert = 0;
    int n_fail   = 0;

    out_align_checker #(.NUM_REQS(2), .WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .pop0(pop0), .pop1(pop1),
        .data_out0(data_out0), .data_out1(data_out1),
        .prop_signal(prop_signal), .mismatch(mismatch),
        .overflow(overflow), .underflow(underflow),
        .count(count), .in_sync(in_sync)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with the given events applied, then inputs return to idle.
    task automatic cyc(input logic [1:0] p0, input logic [7:0] d0,
                       input logic [1:0] p1, input logic [7:0] d1);
        pop0 = p0; data_out0 = d0; pop1 = p1; data_out1 = d1;
        tick();
        pop0 = '0; pop1 = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        tick(); tick();
        chk("rst_prop", prop_signal, 1);
        chk("rst_in_sync", in_sync, 0);
        chk("rst_count", count, 0);
        chk("rst_flags", {mismatch, overflow, underflow}, 3'b000);
        rst = 1'b1;

        // Events in IDLE ignored, including the start cycle
        cyc(2'b01, 8'h11, 2'b00, 8'h00);
        chk("idle_ignore", count, 0);
        start = 1'b1;
        cyc(2'b01, 8'h11, 2'b00, 8'h00);
        start = 1'b0;
        chk("start_cycle_ignore", count, 0);
        chk("track_in_sync", in_sync, 1);

        // Basic aligned transaction, event1 three cycles after event0
        cyc(2'b01, 8'hA5, 2'b00, 8'h00);
        chk("push_count", count, 1);
        chk("push_in_sync", in_sync, 0);
        tick(); tick();
        cyc(2'b00, 8'h00, 2'b01, 8'hA5);
        chk("pop_count", count, 0);
        chk("pop_in_sync", in_sync, 1);
        chk("pop_prop", prop_signal, 1);

        // Simultaneous events on empty buffer: bypass compare
        cyc(2'b10, 8'h3C, 2'b10, 8'h3C);
        chk("bypass_count", count, 0);
        chk("bypass_prop", prop_signal, 1);

        // Fill to full, then simultaneous push/pop with matching head
        cyc(2'b01, 8'h11, 2'b00, 8'h00);
        cyc(2'b10, 8'h22, 2'b00, 8'h00);
        cyc(2'b11, 8'h33, 2'b00, 8'h00);
        cyc(2'b01, 8'h44, 2'b00, 8'h00);
        chk("fill_count", count, 4);
        cyc(2'b10, 8'h55, 2'b01, 8'h11);
        chk("full_simul_count", count, 4);
        chk("full_simul_flags", {mismatch, overflow, underflow, prop_signal}, 4'b0001);

        // Drain through the pointer wrap
        cyc(2'b00, 8'h00, 2'b10, 8'h22);
        cyc(2'b00, 8'h00, 2'b11, 8'h33);
        cyc(2'b00, 8'h00, 2'b01, 8'h44);
        cyc(2'b00, 8'h00, 2'b10, 8'h55);
        chk("drain_count", count, 0);
        chk("drain_ok", {in_sync, prop_signal}, 2'b11);

        // Miscompare on a single buffered entry
        cyc(2'b01, 8'hA5, 2'b00, 8'h00);
        tick(); tick();
`ifdef OUT_ALIGN_DATA_CHK_EN
        cyc(2'b00, 8'h00, 2'b01, 8'hA4);
`else
        cyc(2'b00, 8'h00, 2'b10, 8'hA5);
`endif
        chk("mis_flag", mismatch, 1);
        chk("mis_prop", prop_signal, 0);
        tick();
        chk("mis_sticky", {mismatch, prop_signal}, 2'b10);

        // Mismatch with count=3, frozen in FAIL, then reset mid-operation
        do_reset();
        do_start();
        cyc(2'b01, 8'h10, 2'b00, 8'h00);
        cyc(2'b01, 8'h20, 2'b00, 8'h00);
        cyc(2'b01, 8'h30, 2'b00, 8'h00);
        cyc(2'b01, 8'h40, 2'b00, 8'h00);
        cyc(2'b00, 8'h00, 2'b10, 8'h10);
        chk("mis3_count", count, 3);
        chk("mis3_flags", {mismatch, overflow, underflow, prop_signal}, 4'b1000);
        cyc(2'b01, 8'h50, 2'b00, 8'h00);
        chk("fail_frozen", count, 3);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midrst_count", count, 0);
        chk("midrst_flags", {mismatch, overflow, underflow}, 3'b000);
        chk("midrst_prop", prop_signal, 1);
        chk("midrst_idle", in_sync, 0);
        cyc(2'b01, 8'h66, 2'b00, 8'h00);
        chk("midrst_idle_ignore", count, 0);

        // Underflow
        do_start();
        cyc(2'b00, 8'h00, 2'b10, 8'h00);
        chk("unf_flags", {mismatch, overflow, underflow, prop_signal}, 4'b0010);
        chk("unf_count", count, 0);

        // Overflow on fifth push
        do_reset();
        do_start();
        for (int i = 1; i <= 4; i++) begin
            cyc(2'b01, 8'(i), 2'b00, 8'h00);
            chk("ovf_fill", count, 32'(i));
        end
        chk("ovf_pre_flags", {overflow, prop_signal}, 2'b01);
        cyc(2'b10, 8'h05, 2'b00, 8'h00);
        chk("ovf_count", count, 4);
        chk("ovf_flags", {mismatch, overflow, underflow, prop_signal}, 4'b0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
